// File: rtl/cpu_types_pkg.sv
// Shared types for the memory arbiter: RAM handshake states, word type,
// arbiter FSM states and the request source encoding.
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
  typedef enum logic {ARB, SERVE} arb_state_t;
  typedef enum logic [1:0] {SRC_DW, SRC_DR, SRC_I} src_t;
  localparam int BURST_DEF = 2;
endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selector: first CPU with any request, searching upward from ptr
// (ptr tied to 0 gives fixed lowest-index priority); within a CPU dWEN > dREN > iREN.
module mem_arb_pick import cpu_types_pkg::*; #(
  parameter int CPUS = 2,
  parameter int CW   = (CPUS > 1) ? $clog2(CPUS) : 1
) (
  input  logic [CPUS-1:0] ireq,
  input  logic [CPUS-1:0] drd,
  input  logic [CPUS-1:0] dwr,
  input  logic [CW-1:0]   ptr,
  output logic            valid,
  output logic [CW-1:0]   cpu,
  output src_t            src
);
  int j;

  always_comb begin
    valid = 1'b0;
    cpu   = '0;
    src   = SRC_DR;
    j     = 0;
    for (int k = 0; k < CPUS; k++) begin
      j = int'(ptr) + k;
      if (j >= CPUS) j = j - CPUS;
      if (!valid && (ireq[j] || drd[j] || dwr[j])) begin
        valid = 1'b1;
        cpu   = CW'(j);
        src   = dwr[j] ? SRC_DW : (drd[j] ? SRC_DR : SRC_I);
      end
    end
  end
endmodule

// File: rtl/mem_arb_ctrl.sv
// Arbitrates CPUS icache/dcache pairs onto one RAM port with bursts of up to BURST words.
// Define MEM_ARB_RR_EN for round-robin CPU selection; otherwise lowest CPU index wins.
module mem_arb_ctrl import cpu_types_pkg::*; #(
  parameter int CPUS  = 2,
  parameter int BURST = BURST_DEF
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [CPUS-1:0]     iREN,
  input  logic [CPUS-1:0]     dREN,
  input  logic [CPUS-1:0]     dWEN,
  input  word_t [CPUS-1:0]    iaddr,
  input  word_t [CPUS-1:0]    daddr,
  input  word_t [CPUS-1:0]    dstore,
  output word_t [CPUS-1:0]    iload,
  output word_t [CPUS-1:0]    dload,
  output logic [CPUS-1:0]     iwait,
  output logic [CPUS-1:0]     dwait,
  output logic                ramREN,
  output logic                ramWEN,
  output word_t               ramaddr,
  output word_t               ramstore,
  input  word_t               ramload,
  input  ramstate_t           ramstate
);
  localparam int CW = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam int BW = $clog2(BURST + 1);

  arb_state_t      state_q, state_d;
  logic [CW-1:0]   gcpu_q, gcpu_d;
  src_t            gsrc_q, gsrc_d;
  logic [BW-1:0]   burst_cnt, cnt_d, cnt_inc;
  logic            req_act, done;
  logic            pick_valid;
  logic [CW-1:0]   pick_cpu, pick_ptr;
  src_t            pick_src;

`ifdef MEM_ARB_RR_EN
  logic [CW-1:0]   ptr_q, ptr_d;
  assign pick_ptr = ptr_q;
  assign ptr_d    = (int'(gcpu_q) == CPUS - 1) ? '0 : gcpu_q + CW'(1);

  // Pointer moves past the granted CPU whenever a grant ends.
  always_ff @(posedge CLK) begin
    if (RST)                             ptr_q <= '0;
    else if (state_q == SERVE && done)   ptr_q <= ptr_d;
  end
`else
  assign pick_ptr = '0;
`endif

  mem_arb_pick #(.CPUS(CPUS), .CW(CW)) u_pick (
    .ireq  (iREN),
    .drd   (dREN),
    .dwr   (dWEN),
    .ptr   (pick_ptr),
    .valid (pick_valid),
    .cpu   (pick_cpu),
    .src   (pick_src)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ARB;
      gcpu_q    <= '0;
      gsrc_q    <= SRC_DR;
      burst_cnt <= '0;
    end else begin
      state_q   <= state_d;
      gcpu_q    <= gcpu_d;
      gsrc_q    <= gsrc_d;
      burst_cnt <= cnt_d;
    end
  end

  assign cnt_inc = burst_cnt + BW'(1);

  always_comb begin
    state_d  = state_q;
    gcpu_d   = gcpu_q;
    gsrc_d   = gsrc_q;
    cnt_d    = burst_cnt;
    done     = 1'b0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = '1;
    dwait    = '1;
    iload    = '0;
    dload    = '0;
    case (gsrc_q)
      SRC_DW:  req_act = dWEN[gcpu_q];
      SRC_DR:  req_act = dREN[gcpu_q];
      default: req_act = iREN[gcpu_q];
    endcase

    case (state_q)
      ARB: begin
        if (pick_valid) begin
          state_d = SERVE;
          gcpu_d  = pick_cpu;
          gsrc_d  = pick_src;
          cnt_d   = '0;
        end
      end
      default: begin
        // Enables follow the live request so a dropped request never reaches RAM.
        ramaddr  = (gsrc_q == SRC_I) ? iaddr[gcpu_q] : daddr[gcpu_q];
        ramstore = (gsrc_q == SRC_I) ? '0 : dstore[gcpu_q];
        ramWEN   = req_act && (gsrc_q == SRC_DW);
        ramREN   = req_act && (gsrc_q != SRC_DW);
        if (!req_act) begin
          done = 1'b1;
        end else if (ramstate == ACCESS) begin
          if (gsrc_q == SRC_I) begin
            iwait[gcpu_q] = 1'b0;
            iload[gcpu_q] = ramload;
          end else begin
            dwait[gcpu_q] = 1'b0;
            dload[gcpu_q] = ramload;
          end
          if (int'(cnt_inc) < BURST) cnt_d = cnt_inc;
          else                       done  = 1'b1;
        end
        if (done) begin
          state_d = ARB;
          cnt_d   = '0;
        end
      end
    endcase
  end
endmodule

// File: tb/tb_mem_arb_ctrl.sv
// Scoreboard bench for mem_arb_ctrl: expected wait pulses are queued as stimulus is driven
// and a negedge monitor pops/compares them. Honours MEM_ARB_RR_EN for the fairness test.
module tb_mem_arb_ctrl;
  import cpu_types_pkg::*;

  logic           CLK = 1'b0;
  logic           RST;
  logic [1:0]     iREN, dREN, dWEN;
  word_t [1:0]    iaddr, daddr, dstore, iload, dload;
  logic [1:0]     iwait, dwait;
  logic           ramREN, ramWEN;
  word_t          ramaddr, ramstore, ramload;
  ramstate_t      ramstate;

  typedef struct {bit is_i; int cpu; word_t data;} exp_t;
  exp_t sbq[$];

  int checks = 0;
  int errors = 0;
  int busy_n = 0;
  int err_n  = 0;
  int wcnt   = 0;

  always #5 CLK = ~CLK;

  mem_arb_ctrl #(.CPUS(2), .BURST(2)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
    .iaddr(iaddr), .daddr(daddr), .dstore(dstore),
    .iload(iload), .dload(dload), .iwait(iwait), .dwait(dwait),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  function automatic word_t model(input word_t a);
    return (a == 32'h40) ? 32'hDEADBEEF : (a ^ 32'hA5A5_0000);
  endfunction

  // RAM: err_n ERROR cycles, then busy_n BUSY cycles, then ACCESS.
  always_comb begin
    ramload  = model(ramaddr);
    ramstate = FREE;
    if (ramREN || ramWEN) begin
      if (wcnt < err_n)               ramstate = ERROR;
      else if (wcnt < err_n + busy_n) ramstate = BUSY;
      else                            ramstate = ACCESS;
    end
  end

  always @(posedge CLK) begin
    if ((ramREN || ramWEN) && ramstate != ACCESS) wcnt <= wcnt + 1;
    else                                          wcnt <= 0;
  end

  always @(negedge CLK) begin
    exp_t e;
    checks++;
    if (ramREN && ramWEN) begin
      errors++;
      $display("FAIL mutex: ramREN=%0b ramWEN=%0b required not both 1", ramREN, ramWEN);
    end
    for (int c = 0; c < 2; c++) begin
      for (int s = 0; s < 2; s++) begin
        logic  w;
        word_t ld;
        w  = s[0] ? iwait[c] : dwait[c];
        ld = s[0] ? iload[c] : dload[c];
        checks++;
        if (w && ld !== 32'h0) begin
          errors++;
          $display("FAIL load_zero: cpu%0d is_i=%0d load=%h required 0 while waiting", c, s, ld);
        end
        if (!w) begin
          checks++;
          if (sbq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse: cpu%0d is_i=%0d got pulse, required none", c, s);
          end else begin
            e = sbq.pop_front();
            if (e.cpu != c || e.is_i != s[0] || ld !== e.data) begin
              errors++;
              $display("FAIL pulse: got cpu%0d is_i=%0d load=%h required cpu%0d is_i=%0d load=%h",
                       c, s, ld, e.cpu, e.is_i, e.data);
            end
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_pulse(input bit is_i, input int c, input string nm);
    bit found = 0;
    for (int n = 0; n < 30 && !found; n++) begin
      @(negedge CLK);
      if (!(is_i ? iwait[c] : dwait[c])) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL %s: no wait pulse within 30 cycles, required one", nm);
    end
    step();
  endtask

  task automatic test_reset();
    RST = 1; iREN = '0; dWEN = '0; dREN = 2'b01;
    iaddr = '0; daddr = '0; dstore = '0;
    step(); step();
    @(negedge CLK);
    checks++;
    if (iwait !== 2'b11 || dwait !== 2'b11 || ramREN !== 1'b0 || ramWEN !== 1'b0 ||
        ramaddr !== 32'h0 || ramstore !== 32'h0) begin
      errors++;
      $display("FAIL reset: iwait=%b dwait=%b ren=%b wen=%b addr=%h store=%h required 11 11 0 0 0 0",
               iwait, dwait, ramREN, ramWEN, ramaddr, ramstore);
    end
    step();
    dREN = '0; RST = 0;
    step();
  endtask

  task automatic test_read_latency();
    busy_n = 2; err_n = 0;
    daddr[0] = 32'h40; dREN[0] = 1'b1;
    sbq.push_back('{1'b0, 0, 32'hDEADBEEF});
    step();
    @(negedge CLK);
    checks++;
    if (ramREN !== 1'b1 || ramaddr !== 32'h40 || dwait[0] !== 1'b1) begin
      errors++;
      $display("FAIL lat_c1: ren=%b addr=%h dwait0=%b required 1 00000040 1", ramREN, ramaddr, dwait[0]);
    end
    step();
    @(negedge CLK);
    checks++;
    if (dwait[0] !== 1'b1) begin
      errors++;
      $display("FAIL lat_c2: dwait0=%b required 1", dwait[0]);
    end
    step();
    @(negedge CLK);
    checks++;
    if (dwait[0] !== 1'b0 || dload[0] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL lat_c3: dwait0=%b dload0=%h required 0 deadbeef", dwait[0], dload[0]);
    end
    step();
    dREN[0] = 1'b0;
    step();
    @(negedge CLK);
    checks++;
    if (ramREN !== 1'b0) begin
      errors++;
      $display("FAIL lat_arb: ren=%b required 0", ramREN);
    end
    step();
  endtask

  task automatic test_back_to_back();
    busy_n = 0; err_n = 0;
    daddr[0] = 32'h40; dREN[0] = 1'b1;
    sbq.push_back('{1'b0, 0, 32'hDEADBEEF});
    sbq.push_back('{1'b0, 0, model(32'h44)});
    step();
    @(negedge CLK);
    checks++;
    if (dwait[0] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_w1: dwait0=%b required 0", dwait[0]);
    end
    step();
    daddr[0] = 32'h44;
    @(negedge CLK);
    checks++;
    if (dwait[0] !== 1'b0 || ramaddr !== 32'h44 || dut.burst_cnt !== 2'd1) begin
      errors++;
      $display("FAIL b2b_w2: dwait0=%b addr=%h cnt=%0d required 0 00000044 1",
               dwait[0], ramaddr, dut.burst_cnt);
    end
    step();
    dREN[0] = 1'b0;
    @(negedge CLK);
    checks++;
    if (ramREN !== 1'b0 || dut.burst_cnt !== 2'd0) begin
      errors++;
      $display("FAIL b2b_end: ren=%b cnt=%0d required 0 0", ramREN, dut.burst_cnt);
    end
    step();
  endtask

  task automatic test_write_priority();
    busy_n = 1; err_n = 0;
    iaddr[0] = 32'h100; daddr[0] = 32'h80; dstore[0] = 32'h12345678;
    iREN[0] = 1'b1; dWEN[0] = 1'b1;
    sbq.push_back('{1'b0, 0, model(32'h80)});
    sbq.push_back('{1'b1, 0, model(32'h100)});
    step();
    @(negedge CLK);
    checks++;
    if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramaddr !== 32'h80 ||
        ramstore !== 32'h12345678 || iwait[0] !== 1'b1) begin
      errors++;
      $display("FAIL wr_first: wen=%b ren=%b addr=%h store=%h iwait0=%b required 1 0 00000080 12345678 1",
               ramWEN, ramREN, ramaddr, ramstore, iwait[0]);
    end
    wait_pulse(1'b0, 0, "wr_pulse");
    dWEN[0] = 1'b0;
    wait_pulse(1'b1, 0, "ird_pulse");
    iREN[0] = 1'b0;
    step(); step();
  endtask

  task automatic test_fairness();
    busy_n = 0; err_n = 0;
    daddr[0] = 32'h200; daddr[1] = 32'h300;
    dREN = 2'b11;
`ifdef MEM_ARB_RR_EN
    foreach (sbq[i]) ;
    for (int b = 0; b < 3; b++) begin
      int c = b % 2;
      sbq.push_back('{1'b0, c, model(c ? 32'h300 : 32'h200)});
      sbq.push_back('{1'b0, c, model(c ? 32'h300 : 32'h200)});
    end
`else
    for (int n = 0; n < 6; n++) sbq.push_back('{1'b0, 0, model(32'h200)});
`endif
    for (int n = 0; n < 60 && sbq.size() != 0; n++) @(posedge CLK);
    #1;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL fairness: %0d pulses outstanding, required 0", sbq.size());
    end
    dREN = '0;
    step(); step();
  endtask

  task automatic test_error_retry();
    busy_n = 0; err_n = 3;
    daddr[0] = 32'h400; dREN[0] = 1'b1;
    sbq.push_back('{1'b0, 0, model(32'h400)});
    step();
    for (int n = 0; n < 3; n++) begin
      @(negedge CLK);
      checks++;
      if (dwait[0] !== 1'b1 || ramREN !== 1'b1 || ramstate !== ERROR) begin
        errors++;
        $display("FAIL err_c%0d: dwait0=%b ren=%b state=%0d required 1 1 ERROR", n, dwait[0], ramREN, ramstate);
      end
      step();
    end
    @(negedge CLK);
    checks++;
    if (dwait[0] !== 1'b0 || dload[0] !== model(32'h400)) begin
      errors++;
      $display("FAIL err_done: dwait0=%b dload0=%h required 0 %h", dwait[0], dload[0], model(32'h400));
    end
    step();
    dREN[0] = 1'b0; err_n = 0;
    step(); step();
  endtask

  task automatic test_drop();
    busy_n = 5; err_n = 0;
    iaddr[1] = 32'h600; iREN[1] = 1'b1;
    step();
    @(negedge CLK);
    checks++;
    if (ramREN !== 1'b1 || ramaddr !== 32'h600) begin
      errors++;
      $display("FAIL drop_grant: ren=%b addr=%h required 1 00000600", ramREN, ramaddr);
    end
    step();
    iREN[1] = 1'b0;
    @(negedge CLK);
    checks++;
    if (ramREN !== 1'b0 || iwait[1] !== 1'b1) begin
      errors++;
      $display("FAIL drop_now: ren=%b iwait1=%b required 0 1", ramREN, iwait[1]);
    end
    step();
    @(negedge CLK);
    checks++;
    if (ramREN !== 1'b0 || ramWEN !== 1'b0 || dut.state_q !== ARB) begin
      errors++;
      $display("FAIL drop_arb: ren=%b wen=%b state=%0d required 0 0 ARB", ramREN, ramWEN, dut.state_q);
    end
    step();
  endtask

  task automatic test_reset_mid();
    busy_n = 5; err_n = 0;
    daddr[1] = 32'h500; dREN[1] = 1'b1;
    step();
    @(negedge CLK);
    checks++;
    if (ramREN !== 1'b1 || ramaddr !== 32'h500) begin
      errors++;
      $display("FAIL rstm_grant: ren=%b addr=%h required 1 00000500", ramREN, ramaddr);
    end
    step();
    RST = 1'b1;
    step();
    @(negedge CLK);
    checks++;
    if (iwait !== 2'b11 || dwait !== 2'b11 || ramREN !== 1'b0 || ramWEN !== 1'b0) begin
      errors++;
      $display("FAIL rstm: iwait=%b dwait=%b ren=%b wen=%b required 11 11 0 0", iwait, dwait, ramREN, ramWEN);
    end
    step();
    dREN = '0; RST = 1'b0; busy_n = 0;
    step(); step();
  endtask

  initial begin
    test_reset();
    test_read_latency();
    test_back_to_back();
    test_write_priority();
    test_fairness();
    test_error_retry();
    test_drop();
    test_reset_mid();
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty: %0d entries left, required 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mem_arb_ctrl.md
MEM_ARB_CTRL -- requirements
Module: mem_arb_ctrl

Interface
REQ-001 SHALL have parameter CPUS, default 2, number of cache pairs (icache+dcache) served.
REQ-002 SHALL have parameter BURST, default 2, max consecutive accesses per grant (words per dcache block).
REQ-003 CLK  in  1  single clock; all state updates on rising edge.
REQ-004 RST  in  1  reset, synchronous, active-high.
REQ-005 iREN  in  CPUS  instruction read request per CPU.
REQ-006 dREN, dWEN  in  CPUS each  data read / write request per CPU.
REQ-007 iaddr, daddr  in  CPUS x word_t  request addresses; dstore  in  CPUS x word_t  write data.
REQ-008 iload, dload  out  CPUS x word_t  read data, valid only in the cycle the matching wait is low.
REQ-009 iwait, dwait  out  CPUS each  active-high stall; low for exactly one cycle per completed access.
REQ-010 ramREN, ramWEN  out  1 each; ramaddr, ramstore  out  word_t; ramload  in  word_t; ramstate  in  ramstate_t (FREE, BUSY, ACCESS, ERROR).

Function
REQ-011 SHALL use a two-state FSM: ARB, SERVE.
REQ-012 ARB: if any request pending, latch grant (CPU index, source) and go to SERVE next cycle; else stay ARB; RAM enables 0.
REQ-013 Source priority within a CPU: dWEN > dREN > iREN; dWEN and dREN both high treated as write.
REQ-014 CPU selection: per Configuration section.
REQ-015 SERVE: ramaddr/ramstore/ramREN/ramWEN driven combinationally from the granted source; all other sources see wait=1.
REQ-016 SERVE, ramstate==ACCESS: granted wait=0 that cycle, granted load=ramload; burst counter increments.
REQ-017 SERVE, ramstate FREE or BUSY: wait stays 1, no counter change.
REQ-018 SERVE, ramstate==ERROR: wait stays 1, access retried next cycle; no data returned.
REQ-019 After an ACCESS cycle: stay SERVE if the same source still requests and counter < BURST; else return to ARB, counter cleared.
REQ-020 Granted source dropping its request mid-SERVE (no ACCESS yet): return to ARB next cycle, RAM enables 0 that next cycle.
REQ-021 dload/iload SHALL be 32'h0 for any source whose wait is 1.
REQ-022 Never assert ramREN and ramWEN in the same cycle.

Reset
REQ-023 On RST: state=ARB, grant=CPU0 dcache, burst counter=0, round-robin pointer=0, all iwait/dwait=1, ramREN=ramWEN=0, ramaddr=ramstore=0; RST mid-SERVE aborts the access with no wait pulse.

Configuration
REQ-024 Macro MEM_ARB_RR_EN defined: CPU choice round-robin starting from pointer; pointer = granted CPU+1 mod CPUS on each return to ARB.
REQ-025 MEM_ARB_RR_EN undefined: fixed priority, lowest CPU index with a pending request wins; pointer logic absent.

Structure
REQ-026 ramstate_t, word_t, and arb state enum SHALL live in cpu_types_pkg; BURST default as package constant.
REQ-027 One sub-module, mem_arb_pick, SHALL be natural: combinational selector returning CPU index and source from requests and pointer.

Verification
REQ-028 CPU0 dREN daddr=0x40, ramstate ACCESS after 2 BUSY cycles, ramload=0xDEADBEEF -> dwait[0] low one cycle with dload[0]=0xDEADBEEF, 3 cycles after grant.
REQ-029 CPU0 dREN on 0x40 then 0x44 held -> both served back-to-back in one grant, then ARB; counter back to 0.
REQ-030 CPU0 iREN and dWEN together, dstore=0x12345678 -> write served first with ramWEN=1, ramaddr=daddr; iwait[0] stays 1 until later grant.
REQ-031 Both CPUs dREN continuously, MEM_ARB_RR_EN defined -> grants alternate CPU0, CPU1, CPU0 per 2-word burst; undefined -> CPU1 starved while CPU0 requests.
REQ-032 ramstate=ERROR for 3 cycles then ACCESS -> no wait pulse during ERROR, single dwait pulse after; RST asserted mid-SERVE -> all waits 1, ramREN=0 next cycle.
